// File: rtl/cdc_pkg.sv
// Shared types for the req/ack clock-domain-crossing blocks.
// Holds the sender FSM state enum and the default synchronizer depth.
package cdc_pkg;

  localparam int CDC_SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } hs_tx_state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit N-flop synchronizer with synchronous active-low clear.
// Ports: clk, rstn (sync clear), d (async in), q (last stage).
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  (* async_reg = "true" *) logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Sending end of a 4-phase req/ack crossing; all state on clk.
// Ports: clk, rstn (sync, active-low), in_valid/in_ready/in_data
// upstream, out_req/out_data to far side, ack_async from far side,
// xfer_done pulse when ack returns low, busy when not IDLE.
// Option: define CDC_HS_TX_SKID_EN for a one-entry holding register.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_req,
  output logic [WIDTH-1:0] out_data,
  input  logic             ack_async,
  output logic             xfer_done,
  output logic             busy
);

  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_END = CW'(SYNC_STAGES);

  hs_tx_state_t     state;
  hs_tx_state_t     state_n;
  logic [CW-1:0]    init_cnt;
  logic [CW-1:0]    cnt_n;
  logic             req_n;
  logic [WIDTH-1:0] data_n;
  logic             done_n;
  logic             ack_s;
  logic             accept;

`ifdef CDC_HS_TX_SKID_EN
  logic             skid_vld;
  logic             skv_n;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] skd_n;
`endif

  (* keep_hierarchy = "yes" *)
  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (ack_async),
    .q    (ack_s)
  );

`ifdef CDC_HS_TX_SKID_EN
  assign in_ready = (state != INIT) && !skid_vld;
`else
  assign in_ready = (state == IDLE);
`endif

  assign busy   = (state != IDLE);
  assign accept = in_valid && in_ready;

  always_comb begin
    state_n = state;
    cnt_n   = init_cnt;
    req_n   = out_req;
    data_n  = out_data;
    done_n  = 1'b0;
`ifdef CDC_HS_TX_SKID_EN
    skv_n   = skid_vld;
    skd_n   = skid_data;
`endif
    unique case (state)
      // Saturating count lets a stale ack
      // drain through the synchronizer.
      INIT: begin
        if (init_cnt != CNT_END) begin
          cnt_n = init_cnt + 1'b1;
        end
        if (init_cnt == CNT_END && !ack_s) begin
          state_n = IDLE;
        end
      end
      IDLE: begin
        if (accept) begin
          data_n  = in_data;
          req_n   = 1'b1;
          state_n = REQ;
        end
`ifdef CDC_HS_TX_SKID_EN
        // A word parked on the RELEASE exit
        // edge is launched from here.
        if (skid_vld) begin
          data_n  = skid_data;
          req_n   = 1'b1;
          skv_n   = 1'b0;
          state_n = REQ;
        end
`endif
      end
      REQ: begin
        if (ack_s) begin
          req_n   = 1'b0;
          state_n = RELEASE;
        end
`ifdef CDC_HS_TX_SKID_EN
        if (accept) begin
          skv_n = 1'b1;
          skd_n = in_data;
        end
`endif
      end
      RELEASE: begin
`ifdef CDC_HS_TX_SKID_EN
        if (accept) begin
          skv_n = 1'b1;
          skd_n = in_data;
        end
`endif
        if (!ack_s) begin
          done_n  = 1'b1;
          state_n = IDLE;
`ifdef CDC_HS_TX_SKID_EN
          if (skid_vld) begin
            data_n  = skid_data;
            req_n   = 1'b1;
            skv_n   = 1'b0;
            state_n = REQ;
          end
`endif
        end
      end
      default: begin
        state_n = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= INIT;
      init_cnt  <= '0;
      out_req   <= 1'b0;
      out_data  <= '0;
      xfer_done <= 1'b0;
`ifdef CDC_HS_TX_SKID_EN
      skid_vld  <= 1'b0;
      skid_data <= '0;
`endif
    end else begin
      state     <= state_n;
      init_cnt  <= cnt_n;
      out_req   <= req_n;
      out_data  <= data_n;
      xfer_done <= done_n;
`ifdef CDC_HS_TX_SKID_EN
      skid_vld  <= skv_n;
      skid_data <= skd_n;
`endif
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx.
// Far-side ack model, queue of accepted words, req-edge monitor.
module tb_cdc_handshake_tx;

  localparam int W  = 32;
  localparam int SS = 2;

  logic         clk;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_req;
  logic [W-1:0] out_data;
  logic         ack_async;
  logic         xfer_done;
  logic         busy;

  logic         far_ack;
  logic         hold_ack;
  int           ack_dly;
  bit           rand_dly;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] held;
  logic [W-1:0] mon_e;
  logic         req_q;
  int           rises;
  int           dones;

  assign ack_async = far_ack | hold_ack;

  cdc_handshake_tx #(
    .WIDTH       (W),
    .SYNC_STAGES (SS)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_req   (out_req),
    .out_data  (out_data),
    .ack_async (ack_async),
    .xfer_done (xfer_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Far side: ack after a delay, drop ack once req falls.
  initial begin : far_model
    int d;
    far_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (out_req && !far_ack) begin
        d = rand_dly ? int'($urandom_range(0, 15)) : ack_dly;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (!out_req) break;
        end
        if (out_req) far_ack = 1'b1;
      end else if (!out_req && far_ack) begin
        far_ack = 1'b0;
      end
    end
  end

  // Monitor: each req rise pops the next expected word.
  initial begin : monitor
    req_q = 1'b0;
    rises = 0;
    dones = 0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (out_req && !req_q) begin
        rises++;
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word", 64'(out_data), 64'(mon_e));
        end
        held = out_data;
      end else if (out_req) begin
        chk("data_stable", 64'(out_data), 64'(held));
      end
      if (xfer_done) dones++;
      req_q = out_req;
    end
  end

  task automatic send(input logic [W-1:0] d,
                      output logic acc_busy);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(in_ready), 64'd1);
    acc_busy = busy;
    if (in_ready) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic stop_valid();
    in_valid = 1'b0;
    in_data  = 32'h0BAD_0BAD;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((busy || out_req || far_ack) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  task automatic count_ready_low(output int n);
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   n;
    int   d0;
    logic b;
    checks   = 0;
    errors   = 0;
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    hold_ack = 1'b0;
    ack_dly  = 3;
    rand_dly = 1'b0;

    // Reset values and INIT length with ack low.
    repeat (3) @(negedge clk);
    chk("rst_req",   64'(out_req),   64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_done",  64'(xfer_done), 64'd0);
    chk("rst_ready", 64'(in_ready),  64'd0);
    chk("rst_busy",  64'(busy),      64'd1);
    rstn = 1'b1;
    count_ready_low(n);
    chk("init_len", 64'(n), 64'(SS + 1));
    chk("init_busy", 64'(busy), 64'd0);

    // Stale ack held high across reset.
    rstn     = 1'b0;
    hold_ack = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    b    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) b = 1'b1;
      @(negedge clk);
    end
    chk("stale_ack_ready", 64'(b), 64'd0);
    hold_ack = 1'b0;
    count_ready_low(n);
    chk("stale_ack_len", 64'(n), 64'(SS + 1));

    // Single word, ack 3 cycles after req.
    d0 = dones;
    send(32'hDEAD_BEEF, b);
    stop_valid();
    chk("req_rise", 64'(out_req), 64'd1);
    n = 0;
    while (!ack_async && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ack_seen", 64'(ack_async), 64'd1);
    n = 0;
    while (out_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    // Ack is sampled at the first edge, then SS more edges.
    chk("req_fall", 64'(n), 64'(SS + 1));
    drain(100);
    repeat (2) @(negedge clk);
    chk("beef_done", 64'(dones - d0), 64'd1);
    chk("beef_hold", 64'(out_data), 64'hDEAD_BEEF);

    // Back-to-back 1,2,3 with valid held.
    d0 = dones;
    send(32'd1, b);
    send(32'd2, b);
`ifdef CDC_HS_TX_SKID_EN
    chk("skid_accept", 64'(b), 64'd1);
`else
    chk("idle_accept", 64'(b), 64'd0);
`endif
    send(32'd3, b);
    stop_valid();
    drain(200);
    repeat (2) @(negedge clk);
    chk("b2b_done", 64'(dones - d0), 64'd3);
    chk("b2b_empty", 64'(exp_q.size()), 64'd0);

    // Ack rising in IDLE is ignored.
    hold_ack = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_ack_busy", 64'(busy), 64'd0);
    chk("idle_ack_req",  64'(out_req), 64'd0);
    hold_ack = 1'b0;
    repeat (4) @(negedge clk);

    // Reset while in REQ.
    ack_dly = 15;
    send(32'h0000_0055, b);
    stop_valid();
    repeat (2) @(negedge clk);
    chk("mid_req", 64'(out_req), 64'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_req",  64'(out_req), 64'd0);
    chk("mid_rst_busy", 64'(busy),    64'd1);
    rstn = 1'b1;
    count_ready_low(n);
    chk("mid_rst_init", 64'(n), 64'(SS + 1));
    ack_dly = 2;
    d0 = dones;
    send(32'hA5A5_0001, b);
    stop_valid();
    drain(100);
    repeat (2) @(negedge clk);
    chk("post_rst_done", 64'(dones - d0), 64'd1);

    // 1000 words, random far-side delays.
    rand_dly = 1'b1;
    d0 = dones;
    for (int i = 0; i < 1000; i++) begin
      send(32'(i) * 32'h9E37_79B9 + 32'h1234_5678, b);
    end
    stop_valid();
    drain(500);
    repeat (2) @(negedge clk);
    chk("rand_done",  64'(dones - d0), 64'd1000);
    chk("rand_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
